// File: rtl/i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx_serializer
// Purpose  : Philips I2S transmitter fed one word per slot from an upstream
//            buffer. Optional macro I2S_TX_MONO_DUP_EN sends one word per frame.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_tx_serializer #(
    parameter int WIDTH     = 24,
    parameter int SLOT_BITS = 32,
    parameter int CLK_DIV   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_avail,
    output logic             data_req,
    output logic             bclk,
    output logic             lrclk,
    output logic             sdata,
    output logic             underrun,
    output logic [15:0]      underrun_cnt
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(SLOT_BITS);
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] c_BIT_LAST = BIT_W'(SLOT_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_WAIT    = 2'd2,
        S_CAPTURE = 2'd3
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div_cnt;
    logic [BIT_W-1:0] r_bit_cnt;
    logic             r_bclk;
    logic             r_lrclk;
    logic             r_sdata;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_hold;
    logic             r_data_req;
    logic             r_underrun;
    logic [15:0]      r_underrun_cnt;

    logic w_div_wrap;
    logic w_fall_tick;
    logic w_slot_wrap;
    logic w_fetch_start;

    assign w_div_wrap  = (r_div_cnt == c_DIV_LAST);
    assign w_fall_tick = w_div_wrap & r_bclk;
    assign w_slot_wrap = w_fall_tick & (r_bit_cnt == c_BIT_LAST);

`ifdef I2S_TX_MONO_DUP_EN
    // Fetch only when the right slot ends; hold_reg then feeds both channels.
    assign w_fetch_start = w_slot_wrap & r_lrclk;
`else
    assign w_fetch_start = w_slot_wrap;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_bclk    <= 1'b0;
            r_lrclk   <= 1'b0;
            r_sdata   <= 1'b0;
            r_shift   <= '0;
        end else begin
            r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
            if (w_div_wrap) begin
                r_bclk <= ~r_bclk;
            end
            if (w_fall_tick) begin
                // Old MSB goes out before the reload, giving the one-BCLK delay.
                r_sdata <= r_shift[WIDTH-1];
                if (r_bit_cnt == c_BIT_LAST) begin
                    r_bit_cnt <= '0;
                    r_lrclk   <= ~r_lrclk;
                    r_shift   <= r_hold;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                    r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_hold         <= '0;
            r_data_req     <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_data_req <= 1'b0;
            r_underrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fetch_start) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (data_avail) begin
                        r_data_req <= 1'b1;
                        r_state    <= S_WAIT;
                    end else begin
                        r_hold     <= '0;
                        r_underrun <= 1'b1;
                        if (r_underrun_cnt != 16'hFFFF) begin
                            r_underrun_cnt <= r_underrun_cnt + 16'd1;
                        end
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_hold  <= data_in;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_req     = r_data_req;
    assign bclk         = r_bclk;
    assign lrclk        = r_lrclk;
    assign sdata        = r_sdata;
    assign underrun     = r_underrun;
    assign underrun_cnt = r_underrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx_serializer
// Purpose  : Scoreboard bench for i2s_tx_serializer (honours I2S_TX_MONO_DUP_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_tx_serializer;

    localparam int WIDTH     = 24;
    localparam int SLOT_BITS = 32;
    localparam int CLK_DIV   = 2;
    localparam int BCLK_CLK  = 2 * CLK_DIV;
    localparam int SLOT_CLK  = SLOT_BITS * BCLK_CLK;

    logic             clk        = 1'b0;
    logic             rst_n      = 1'b0;
    logic [WIDTH-1:0] data_in    = '0;
    logic             data_avail = 1'b0;
    logic             data_req;
    logic             bclk;
    logic             lrclk;
    logic             sdata;
    logic             underrun;
    logic [15:0]      underrun_cnt;

    i2s_tx_serializer #(
        .WIDTH    (WIDTH),
        .SLOT_BITS(SLOT_BITS),
        .CLK_DIV  (CLK_DIV)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_in     (data_in),
        .data_avail  (data_avail),
        .data_req    (data_req),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          req;
        int          und;
        logic [15:0] cnt;
    } ev_t;

    logic [31:0]      data_q[$];
    ev_t              ev_q[$];
    logic [WIDTH-1:0] up_q[$];
    int               n_cmp  = 0;
    int               n_fail = 0;
    int               tcyc   = 0;

    // Clock edges since reset release: outputs seen after edge t are a pure function of t.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcyc <= 0;
        else        tcyc <= tcyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit fetch_slot(input int s);
`ifdef I2S_TX_MONO_DUP_EN
        return (s >= 2) && (s % 2 == 0);
`else
        return s >= 1;
`endif
    endfunction

    // Slot whose fetch supplies the word played in slot w, or -1 for zeros.
    function automatic int src_slot(input int w);
`ifdef I2S_TX_MONO_DUP_EN
        return (w >= 3) ? ((w - 1) / 2) * 2 : -1;
`else
        return (w >= 2) ? w - 1 : -1;
`endif
    endfunction

    task automatic wait_t(input int x);
        while (tcyc < x) @(negedge clk);
    endtask

    initial begin : upstream
        forever begin
            @(negedge clk);
            if (rst_n && data_req === 1'b1) begin
                @(posedge clk);
                #1;
                if (up_q.size() > 0) data_in = up_q.pop_front();
            end
        end
    end

    initial begin : monitor
        int          t;
        int          bad_clk;
        int          req_n;
        int          und_n;
        logic [31:0] acc;
        ev_t         e;
        bad_clk = 0; req_n = 0; und_n = 0; acc = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bad_clk = 0; req_n = 0; und_n = 0; acc = '0;
            end else begin
                t = tcyc;
                if (bclk !== 1'((t / CLK_DIV) % 2) || lrclk !== 1'((t / SLOT_CLK) % 2)) bad_clk++;
                if (data_req === 1'b1) req_n++;
                if (underrun === 1'b1) und_n++;
                if (t >= BCLK_CLK && t % BCLK_CLK == 2) begin
                    acc = {acc[30:0], sdata};
                    if ((t / BCLK_CLK - 1) % SLOT_BITS == SLOT_BITS - 1) begin
                        if (data_q.size() == 0) begin
                            n_cmp++; n_fail++;
                            $display("FAIL sdata_slot: got %0h expected none queued at %0t", acc, $time);
                        end else begin
                            check("sdata_slot", 64'(acc), 64'(data_q.pop_front()));
                        end
                    end
                end
                if (t % SLOT_CLK == SLOT_CLK - 1) begin
                    check("bclk_lrclk_err_cycles", 64'(bad_clk), 64'd0);
                    if (ev_q.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL slot_events: got req=%0d und=%0d expected none queued", req_n, und_n);
                    end else begin
                        e = ev_q.pop_front();
                        check("data_req_cycles", 64'(req_n), 64'(e.req));
                        check("underrun_cycles", 64'(und_n), 64'(e.und));
                        check("underrun_cnt", 64'(underrun_cnt), 64'(e.cnt));
                    end
                    bad_clk = 0; req_n = 0; und_n = 0;
                end
            end
        end
    end

    // mode 0: never available; 1: directed words then random; 2: random with a forced-0 run.
    task automatic run_phase(input int mode, input int n, input bit abort, input int force_at);
        bit               av[];
        logic [WIDTH-1:0] res[];
        int               cnt;
        int               nw;
        int               src;
        ev_t              e;
        av  = new[n + 1];
        res = new[n + 1];
        cnt = 0;
        nw  = 0;
        for (int s = 0; s <= n; s++) begin
            case (mode)
                0:       av[s] = 1'b0;
                1:       av[s] = (s == 1 || s == 2) ? 1'b1 : (s == 4) ? 1'b0 : ($urandom_range(3) != 0);
                default: av[s] = (s > force_at && s <= force_at + 3) ? 1'b0 : ($urandom_range(3) != 0);
            endcase
            e.req = 0; e.und = 0; res[s] = '0;
            if (fetch_slot(s)) begin
                if (av[s]) begin
                    if (mode == 1 && nw == 0)      res[s] = 24'hA5A5A5;
                    else if (mode == 1 && nw == 1) res[s] = 24'h123456;
                    else                           res[s] = WIDTH'($urandom);
                    nw++;
                    up_q.push_back(res[s]);
                    e.req = 1;
                end else begin
                    e.und = 1;
                    if (cnt < 32'hFFFF) cnt++;
                end
            end
            if (s == force_at) cnt = 32'hFFFE;
            e.cnt = 16'(cnt);
            if (s < n) ev_q.push_back(e);
        end
        for (int w = 0; w < n; w++) begin
            src = src_slot(w);
            data_q.push_back(src < 0 ? 32'h0 : {res[src], 8'h00});
        end

        data_avail = av[0];
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        for (int s = 0; s < n; s++) begin
            wait_t(SLOT_CLK * s + SLOT_CLK / 2);
            data_avail = av[s + 1];
            if (s == force_at) begin
                force dut.r_underrun_cnt = 16'hFFFE;
                @(negedge clk);
                release dut.r_underrun_cnt;
            end
        end
        // Abort lands mid-slot with ten bits already shifted.
        wait_t(abort ? SLOT_CLK * n + 10 * BCLK_CLK + 2 : SLOT_CLK * n + 10);
        check("scoreboard_drain", 64'(data_q.size() + ev_q.size()), 64'd0);
        #2 rst_n = 1'b0;
        #1;
        if (abort) begin
            check("async_rst_bclk", 64'(bclk), 64'd0);
            check("async_rst_lrclk", 64'(lrclk), 64'd0);
            check("async_rst_sdata", 64'(sdata), 64'd0);
            check("async_rst_data_req", 64'(data_req), 64'd0);
        end
        data_q.delete();
        ev_q.delete();
        up_q.delete();
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_bclk", 64'(bclk), 64'd0);
        check("reset_lrclk", 64'(lrclk), 64'd0);
        check("reset_sdata", 64'(sdata), 64'd0);
        check("reset_data_req", 64'(data_req), 64'd0);
        check("reset_underrun", 64'(underrun), 64'd0);
        check("reset_underrun_cnt", 64'(underrun_cnt), 64'd0);
        run_phase(0, 4, 1'b0, -1);
        run_phase(1, 9, 1'b1, -1);
        run_phase(2, 14, 1'b0, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
